// File: rtl/traceback_reader.sv
// Walks a stored traceback path from (0,0) to the end cell. Each coordinate
// step is turned into one alignment symbol, sent out with a valid/ready handshake.
module traceback_reader #(
  parameter int         LENGTH      = 10,
  parameter int         CWIDTH      = 2,
  parameter int         CORD_LENGTH = 8,
  parameter int         ADDR_WIDTH  = 5,
  parameter logic [1:0] TOP_DIR     = 2'b00,
  parameter logic [1:0] LEFT_DIR    = 2'b01,
  parameter logic [1:0] CORNER_DIR  = 2'b10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      count,
  input  logic [LENGTH*CWIDTH-1:0]   s1,
  input  logic [LENGTH*CWIDTH-1:0]   s2,
  output logic                       ren,
  output logic [ADDR_WIDTH-1:0]      raddr,
  input  logic [2*CORD_LENGTH-1:0]   rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_op,
  output logic [CWIDTH-1:0]          out_c1,
  output logic [CWIDTH-1:0]          out_c2,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int SW = LENGTH*CWIDTH;
  localparam int DW = 2*CORD_LENGTH;
  localparam logic [CORD_LENGTH-1:0] LAST_CORD = CORD_LENGTH'(LENGTH-1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_EMIT, S_DONE, S_ERR} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    first_q;
  logic                    cph_q;
  logic [DW-1:0]           wd_q, prev_q;
  logic [1:0]              op_q;
  logic [CWIDTH-1:0]       c1_q, c2_q;
  logic                    last_q;

  logic                    start_acc;
  logic [CORD_LENGTH-1:0]  x, y, dx, dy;
  logic                    viol;
  logic [1:0]              step_op;
  logic [CWIDTH-1:0]       step_c1, step_c2;

  function automatic logic [CWIDTH-1:0] char_at(input logic [SW-1:0] s,
                                                input logic [CORD_LENGTH-1:0] idx);
    logic [CWIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < LENGTH; k++)
      if (idx == CORD_LENGTH'(k)) r = s[(LENGTH-1-k)*CWIDTH +: CWIDTH];
    return r;
  endfunction

  assign start_acc = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

  assign x  = wd_q[DW-1:CORD_LENGTH];
  assign y  = wd_q[CORD_LENGTH-1:0];
  assign dx = x - prev_q[DW-1:CORD_LENGTH];
  assign dy = y - prev_q[CORD_LENGTH-1:0];

  // Classify the captured word against the previous one; wd_q is stable in phase 1.
  always_comb begin
    step_op = CORNER_DIR;
    viol    = 1'b0;
    if (first_q) begin
      viol = (x != '0) || (y != '0);
    end else if (dx == CORD_LENGTH'(1) && dy == CORD_LENGTH'(1)) begin
      step_op = CORNER_DIR;
    end else if (dx == '0 && dy == CORD_LENGTH'(1)) begin
      step_op = TOP_DIR;
    end else if (dx == CORD_LENGTH'(1) && dy == '0) begin
      step_op = LEFT_DIR;
    end else begin
      viol = 1'b1;
    end
    if (x > LAST_CORD || y > LAST_CORD) viol = 1'b1;
    if (addr_q == '0 && (x != LAST_CORD || y != LAST_CORD)) viol = 1'b1;
    step_c1 = (step_op == LEFT_DIR) ? '0 : char_at(s1, y);
    step_c2 = (step_op == TOP_DIR)  ? '0 : char_at(s2, x);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR:
        if (start_acc) state_d = (count == '0) ? S_ERR : S_READ;
      S_READ:    state_d = S_CAPTURE;
      // Phase 0 latches rdata, phase 1 validates the latched word.
      S_CAPTURE: if (cph_q) state_d = viol ? S_ERR : S_EMIT;
      S_EMIT:    if (out_ready) state_d = (addr_q == '0) ? S_DONE : S_READ;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ren       = (state_q == S_READ);
    raddr     = addr_q;
    out_valid = (state_q == S_EMIT);
    busy      = (state_q == S_READ) || (state_q == S_CAPTURE) || (state_q == S_EMIT);
    done      = (state_q == S_DONE);
    error     = (state_q == S_ERR);
    out_op    = op_q;
    out_c1    = c1_q;
    out_c2    = c2_q;
    out_last  = last_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      first_q <= 1'b0;
      cph_q   <= 1'b0;
      wd_q    <= '0;
      prev_q  <= '0;
      op_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      cph_q <= (state_q == S_CAPTURE) && !cph_q;
      if (start_acc) begin
        addr_q  <= count - ADDR_WIDTH'(1);
        first_q <= 1'b1;
      end
      if (state_q == S_CAPTURE && !cph_q) wd_q <= rdata;
      if (state_q == S_CAPTURE && cph_q && !viol) begin
        op_q    <= step_op;
        c1_q    <= step_c1;
        c2_q    <= step_c2;
        last_q  <= (addr_q == '0);
        prev_q  <= wd_q;
        first_q <= 1'b0;
      end
      if (state_q == S_EMIT && out_ready && addr_q != '0) addr_q <= addr_q - ADDR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_traceback_reader.sv
// Directed bench for traceback_reader: expected symbols are queued by the driver
// and popped by a monitor on each handshake.
module tb_traceback_reader;
  localparam int L = 3, CW = 2, CL = 8, AW = 5;

  logic              clk = 1'b0, reset = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [AW-1:0]     count = '0;
  logic [L*CW-1:0]   s1 = '0, s2 = '0;
  logic              ren, out_valid, out_last, busy, done, error;
  logic [AW-1:0]     raddr;
  logic [2*CL-1:0]   rdata = '0;
  logic [1:0]        out_op;
  logic [CW-1:0]     out_c1, out_c2;

  localparam logic [1:0] TOP = 2'b00, LEFT = 2'b01, CORNER = 2'b10;

  traceback_reader #(.LENGTH(L), .CWIDTH(CW), .CORD_LENGTH(CL), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count), .s1(s1), .s2(s2),
    .ren(ren), .raddr(raddr), .rdata(rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_c1(out_c1), .out_c2(out_c2), .out_last(out_last),
    .busy(busy), .done(done), .error(error));

  always #5 clk = ~clk;

  logic [15:0] mem [0:31];
  always @(posedge clk) if (ren) rdata <= mem[raddr];

  typedef struct packed {logic [1:0] op; logic [1:0] c1; logic [1:0] c2; logic last;} sym_t;
  sym_t sb[$];
  int   checks = 0, fails = 0, cyc = 0, ref_cyc = 0;
  bit   ren_seen = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: latency, hold-stability while stalled, and scoreboard pops.
  sym_t held;
  bit   vld_prev = 1'b0, rdy_prev = 1'b0;
  always @(negedge clk) begin
    sym_t got, exp;
    got = {out_op, out_c1, out_c2, out_last};
    if (ren) ren_seen = 1'b1;
    if (out_valid && !vld_prev) chk("latency", 32'(cyc - ref_cyc), 32'd3);
    if (out_valid && vld_prev && !rdy_prev) begin
      chk("hold_payload", 32'(got), 32'(held));
      chk("no_ren_while_stalled", 32'(ren), 32'd0);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_symbol: got %0h expected none", got);
      end else begin
        exp = sb.pop_front();
        chk("symbol", 32'(got), 32'(exp));
        if (!exp.last) ref_cyc = cyc + 1;
      end
    end
    if (error) chk("err_no_valid", 32'(out_valid), 32'd0);
    held = got; vld_prev = out_valid; rdy_prev = out_ready;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [1:0] c1, input logic [1:0] c2, input logic last);
    sb.push_back({op, c1, c2, last});
  endtask

  task automatic do_start(input logic [AW-1:0] c);
    start = 1'b1; count = c; ref_cyc = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk({name, "_valid_seen"}, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_end(input string name, input bit exp_err);
    int n = 0;
    while (!(done || error) && n < 200) begin tick(); n++; end
    chk({name, "_done"},     32'(done),  32'(!exp_err));
    chk({name, "_error"},    32'(error), 32'(exp_err));
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({ren, raddr, out_valid, out_op, out_c1, out_c2, out_last, busy, done, error});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    tick(2);
    chk("reset_outputs", all_outs(), 32'd0);
    reset = 1'b1;
    tick();

    // Diagonal path; a start pulse while busy plus a count change must be ignored.
    s1 = 6'b000110; s2 = 6'b000110;
    mem[2] = 16'h0000; mem[1] = 16'h0101; mem[0] = 16'h0202;
    push(CORNER, 2'b00, 2'b00, 1'b0);
    push(CORNER, 2'b01, 2'b01, 1'b0);
    push(CORNER, 2'b10, 2'b10, 1'b1);
    do_start(3);
    chk("busy_after_start", 32'(busy), 32'd1);
    tick();
    start = 1'b1; count = 5'd1;
    tick();
    start = 1'b0;
    wait_end("diag", 1'b0);

    // Mixed ops with a 5-cycle stall on the first symbol.
    s1 = 6'b111001; s2 = 6'b011011;
    mem[3] = 16'h0000; mem[2] = 16'h0001; mem[1] = 16'h0102; mem[0] = 16'h0202;
    push(CORNER, 2'b11, 2'b01, 1'b0);
    push(TOP,    2'b10, 2'b00, 1'b0);
    push(CORNER, 2'b01, 2'b10, 1'b0);
    push(LEFT,   2'b00, 2'b11, 1'b1);
    out_ready = 1'b0;
    do_start(4);
    chk("done_cleared", 32'(done), 32'd0);
    count = 5'd0;
    wait_valid("stall");
    tick(5);
    out_ready = 1'b1;
    wait_end("mixed", 1'b0);

    // Bad first word, then count==0 start.
    mem[2] = 16'h0100;
    do_start(3);
    wait_end("firstword", 1'b1);
    ren_seen = 1'b0;
    do_start(0);
    chk("cnt0_error", 32'(error), 32'd1);
    chk("cnt0_busy",  32'(busy),  32'd0);
    tick(3);
    chk("cnt0_no_ren", 32'(ren_seen), 32'd0);

    // Illegal step (2,2) after (0,0).
    mem[1] = 16'h0000; mem[0] = 16'h0202;
    push(CORNER, 2'b11, 2'b01, 1'b0);
    do_start(2);
    chk("error_cleared", 32'(error), 32'd0);
    wait_end("badstep", 1'b1);

    // Legal step but wrong end cell at address 0.
    mem[1] = 16'h0000; mem[0] = 16'h0101;
    push(CORNER, 2'b11, 2'b01, 1'b0);
    do_start(2);
    wait_end("badend", 1'b1);

    // Reset during EMIT, then a full rerun.
    s1 = 6'b000110; s2 = 6'b000110;
    mem[2] = 16'h0000; mem[1] = 16'h0101; mem[0] = 16'h0202;
    push(CORNER, 2'b00, 2'b00, 1'b0);
    out_ready = 1'b0;
    do_start(3);
    wait_valid("pre_reset");
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    chk("reset_mid_emit", all_outs(), 32'd0);
    tick(2);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    push(CORNER, 2'b00, 2'b00, 1'b0);
    push(CORNER, 2'b01, 2'b01, 1'b0);
    push(CORNER, 2'b10, 2'b10, 1'b1);
    do_start(3);
    wait_end("after_reset", 1'b0);

    tick(3);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/traceback_reader.md
TRACEBACK_READER -- requirements
Module: traceback_reader

Interface
REQ-001 SHALL have parameter LENGTH, default 10, characters per string.
REQ-002 SHALL have parameter CWIDTH, default 2, bits per character.
REQ-003 SHALL have parameter CORD_LENGTH, default 8, bits per coordinate.
REQ-004 SHALL have parameter ADDR_WIDTH, default 5, traceback memory address bits.
REQ-005 SHALL have parameters TOP_DIR, LEFT_DIR and CORNER_DIR, defaults 2'b00, 2'b01 and 2'b10, the op codes.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  in  1  single-cycle request to decode a stored traceback.
REQ-009 SHALL have port count  in  ADDR_WIDTH  number of stored coordinate words.
REQ-010 SHALL have port s1, s2  in  LENGTH*CWIDTH  aligned strings; character i sits at bits ((LENGTH-1)-i)*CWIDTH +: CWIDTH.
REQ-011 SHALL have port ren  out  1  memory read enable.
REQ-012 SHALL have port raddr  out  ADDR_WIDTH  memory read address.
REQ-013 SHALL have port rdata  in  2*CORD_LENGTH  read word {x,y}, with x in the upper half.
REQ-014 SHALL have port out_valid  out  1  alignment symbol valid.
REQ-015 SHALL have port out_ready  in  1  consumer accepts symbol.
REQ-016 SHALL have port out_op  out  2  TOP_DIR, LEFT_DIR or CORNER_DIR.
REQ-017 SHALL have port out_c1, out_c2  out  CWIDTH  s1 and s2 characters; the gap side is driven 0.
REQ-018 SHALL have port out_last  out  1  marks the final symbol.
REQ-019 SHALL have port busy, done, error  out  1 each  status.

Function
REQ-020 Memory layout SHALL be fixed: address 0 holds end cell (LENGTH-1,LENGTH-1); address count-1 holds (0,0); memory read latency is 1 cycle (rdata valid the cycle after ren).
REQ-021 Address walk SHALL run from count-1 down to 0, so symbols emerge in forward alignment order.
REQ-022 FSM states SHALL be IDLE, READ, CAPTURE, EMIT, DONE and ERR.
REQ-023 IDLE SHALL move to READ on start; busy=1 in READ, CAPTURE and EMIT.
REQ-024 READ SHALL drive ren=1 with raddr = current address for exactly one cycle, then move to CAPTURE.
REQ-025 CAPTURE SHALL register rdata, then go to EMIT, or go to ERR on a violation.
REQ-026 First word SHALL equal (0,0), else ERR; it emits op CORNER_DIR, c1=s1[0], c2=s2[0].
REQ-027 Each later word SHALL be diffed against the previous word as dx=x-xprev and dy=y-yprev, both unsigned CORD_LENGTH.
REQ-028 (dx,dy)=(1,1) SHALL emit CORNER_DIR, c1=s1[y], c2=s2[x].
REQ-029 (dx,dy)=(0,1) SHALL emit TOP_DIR, c1=s1[y], c2=0.
REQ-030 (dx,dy)=(1,0) SHALL emit LEFT_DIR, c1=0, c2=s2[x].
REQ-031 Any other (dx,dy), or an x or y >= LENGTH, SHALL go to ERR.
REQ-032 EMIT SHALL hold out_valid and all out_* stable until out_valid&&out_ready.
REQ-033 On that handshake, EMIT SHALL go to DONE if the address was 0, else decrement the address and go to READ.
REQ-034 out_last SHALL be 1 only for the symbol from address 0.
REQ-035 Latency SHALL be fixed: out_valid rises 3 cycles after start is sampled, and 3 cycles after each non-final handshake.
REQ-036 DONE SHALL hold done=1.
REQ-037 ERR SHALL hold error=1 with out_valid=0.
REQ-038 DONE and ERR SHALL return to READ on the next start, clearing done and error.
REQ-039 start while busy SHALL be ignored.
REQ-040 count==0 at start SHALL go to ERR the next cycle with no read.
REQ-041 count SHALL be sampled at start; later changes are ignored.
REQ-042 An end cell at address 0 other than (LENGTH-1,LENGTH-1) SHALL go to ERR instead of EMIT.

Reset
REQ-043 reset low SHALL asynchronously force IDLE.
REQ-044 reset low SHALL clear ren, raddr, out_valid, out_op, out_c1, out_c2, out_last, busy, done and error to 0.
REQ-045 Reset mid-operation SHALL abandon the walk with no further symbol.
REQ-046 Operation SHALL resume on the first clock edge after reset goes high.

Verification
REQ-047 LENGTH=3, count=3, mem[2]=0x0000, mem[1]=0x0101, mem[0]=0x0202, s1=s2=6'b000110 -> three CORNER_DIR symbols, c1=c2=00,01,10, out_last on 3rd, done=1.
REQ-048 LENGTH=3, count=4, mem[3]=0x0000, mem[2]=0x0001, mem[1]=0x0102, mem[0]=0x0202 -> CORNER_DIR, TOP_DIR(c2=0), CORNER_DIR, LEFT_DIR(c1=0), last on 4th.
REQ-049 out_ready low 5 cycles during first symbol -> out_valid and payload held stable; no ren issued until accept.
REQ-050 mem[count-1]=0x0100 -> error=1 after CAPTURE, no out_valid; a second start with count=0 -> error=1, ren never asserted.
REQ-051 Step word 0x0202 after 0x0000 -> ERR; start pulsed while busy -> ignored, sequence unchanged.
REQ-052 reset low during EMIT -> all outputs 0 immediately; new start -> full sequence re-emitted from (0,0).
